// File: rtl/softmax_normalizer_if.sv
// rtl/softmax_normalizer_if.sv - input, reciprocal and output stream bundle for softmax_normalizer
interface softmax_normalizer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [7:0]        recip_in;
  logic [7:0]        recip_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_data, recip_out, out_ready,
    output in_ready, recip_in, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, recip_out, out_ready,
    input  in_ready, recip_in, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/softmax_normalizer.sv
// rtl/softmax_normalizer.sv - sums a vector, normalizes it for a reciprocal unit, streams x_i/sum
module softmax_normalizer #(
  parameter int N_ELEM    = 4,
  parameter int DATA_W    = 8,
  parameter int RECIP_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  softmax_normalizer_if.slave bus
);
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int SUM_W  = DATA_W + IDX_W;
  localparam int P_W    = $clog2(SUM_W);
  localparam int PROD_W = DATA_W + 8;
  localparam int WAIT_W = (RECIP_LAT > 1) ? $clog2(RECIP_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {S_FILL, S_NORM, S_WAIT, S_EMIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_k;
  logic [SUM_W-1:0]   r_sum;
  logic [DATA_W-1:0]  r_buf [N_ELEM];
  logic [P_W-1:0]     r_shift;
  logic [7:0]         r_recip_in;
  logic [7:0]         r_recip;
  logic               r_recip_ok;
  logic [WAIT_W-1:0]  r_wait;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [P_W-1:0]     w_msb;
  logic [7:0]         w_norm;
  logic [7:0]         w_r;
  logic [PROD_W-1:0]  w_prod;
  logic [PROD_W-1:0]  w_scaled;

  assign w_in_fire  = (r_state == S_FILL) && bus.in_valid;
  assign w_out_fire = (r_state == S_EMIT) && bus.out_ready;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (r_sum[i]) w_msb = P_W'(i);
    end
  end

  // Aligns the leading one of sum to bit 7; bits below p-7 are dropped (floor)
  assign w_norm = 8'({r_sum, 7'b0} >> w_msb);

  // The first EMIT cycle reads the reciprocal straight from the unit, then it is held locally
  assign w_r      = r_recip_ok ? r_recip : bus.recip_out;
  assign w_prod   = PROD_W'(r_buf[r_k]) * PROD_W'(w_r);
  assign w_scaled = w_prod >> r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: if (w_in_fire && (r_count == LAST_IDX)) w_next = S_NORM;
      S_NORM: w_next = (r_sum == '0) ? S_EMIT : S_WAIT;
      S_WAIT: if (r_wait == WAIT_W'(RECIP_LAT - 1)) w_next = S_EMIT;
      S_EMIT: if (w_out_fire && (r_k == LAST_IDX)) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_FILL);
    bus.out_valid = (r_state == S_EMIT);
    bus.out_last  = (r_state == S_EMIT) && (r_k == LAST_IDX);
    bus.out_data  = '0;
    if (r_state == S_EMIT) begin
      bus.out_data = (|w_scaled[PROD_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_scaled[DATA_W-1:0];
    end
    bus.recip_in  = r_recip_in;
    bus.busy      = !((r_state == S_FILL) && (r_count == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_k        <= '0;
      r_sum      <= '0;
      r_shift    <= '0;
      r_recip_in <= '0;
      r_recip    <= '0;
      r_recip_ok <= 1'b0;
      r_wait     <= '0;
      for (int i = 0; i < N_ELEM; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_buf[r_count] <= bus.in_data;
            r_sum          <= r_sum + SUM_W'(bus.in_data);
            r_count        <= r_count + 1'b1;
          end
        end
        S_NORM: begin
          r_shift <= w_msb;
          r_wait  <= '0;
          if (r_sum == '0) begin
            r_recip_in <= '0;
            r_recip    <= '0;
            r_recip_ok <= 1'b1;
          end else begin
            r_recip_in <= w_norm;
            r_recip_ok <= 1'b0;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait + 1'b1;
        end
        S_EMIT: begin
          if (!r_recip_ok) begin
            r_recip    <= bus.recip_out;
            r_recip_ok <= 1'b1;
          end
          if (w_out_fire) begin
            if (r_k == LAST_IDX) begin
              r_k     <= '0;
              r_count <= '0;
              r_sum   <= '0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_normalizer.sv
// tb/tb_softmax_normalizer.sv - directed vectors for softmax_normalizer with a registered reciprocal model
module tb_softmax_normalizer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_normalizer_if #(.DATA_W(8)) bus ();

  softmax_normalizer #(.N_ELEM(4), .DATA_W(8), .RECIP_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] recip_f(input logic [7:0] x);
    case (x)
      8'h80:   return 8'hFF;
      8'hB4:   return 8'hB6;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.recip_out <= 8'h00;
    else        bus.recip_out <= recip_f(bus.recip_in);
  end

  task automatic send4(input logic [31:0] vec, output int t0);
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[8*i +: 8];
      @(posedge clk);
      #1;
      if (i == 0) t0 = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic run_vector(input string name, input logic [31:0] vec, input logic [31:0] expv,
                            input logic [7:0] exp_recip, input int exp_lat, input bit bp);
    int t0;
    int lat;
    bit seen;
    logic [7:0] e;
    send4(vec, t0);
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s out_valid_timeout: got no out_valid, want out_valid within 20 cycles", name);
      return;
    end
    lat = cyc + 1 - t0;
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (bus.recip_in !== exp_recip) begin
      n_fail++;
      $display("FAIL %s recip_in: got %h want %h", name, bus.recip_in, exp_recip);
    end
    for (int i = 0; i < 4; i++) begin
      e = expv[8*i +: 8];
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.out_last !== (i == 3) || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s elem%0d: got valid=%b data=%0d last=%b in_ready=%b want valid=1 data=%0d last=%b in_ready=0",
                 name, i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, e, (i == 3));
      end
      if (bp && i == 1) begin
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_elem1: got valid=%b data=%0d last=%b in_ready=%b want valid=1 data=%0d last=0 in_ready=0",
                     name, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, e);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_last: got valid=%b last=%b in_ready=%b busy=%b want 0 0 1 0",
               name, bus.out_valid, bus.out_last, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #12;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.recip_in !== 8'h00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got in_ready=%b valid=%b last=%b data=%h recip_in=%h busy=%b want 1 0 0 00 00 0",
               bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.recip_in, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    run_vector("uniform64", 32'h40404040, 32'h3F3F3F3F, 8'h80, 6, 1'b0);
  endtask

  task automatic test_single_one();
    run_vector("single_one", 32'h00000001, 32'h000000FF, 8'h80, 6, 1'b0);
  endtask

  task automatic test_zero_sum();
    run_vector("zero_sum", 32'h00000000, 32'h00000000, 8'h00, 5, 1'b0);
  endtask

  task automatic test_mixed();
    run_vector("mixed", 32'h0A3264C8, 32'h0723478E, 8'hB4, 6, 1'b0);
  endtask

  task automatic test_backpressure();
    run_vector("backpressure", 32'h0A3264C8, 32'h0723478E, 8'hB4, 6, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_vector("b2b_first", 32'h40404040, 32'h3F3F3F3F, 8'h80, 6, 1'b0);
    run_vector("b2b_second", 32'h00000001, 32'h000000FF, 8'h80, 6, 1'b0);
  endtask

  task automatic test_reset_abort();
    int  t0;
    bit  seen;
    send4(32'h40404040, t0);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.recip_in !== 8'h80 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait_pre: got busy=%b recip_in=%h valid=%b want 1 80 0", bus.busy, bus.recip_in, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.recip_in !== 8'h00 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_wait: got in_ready=%b valid=%b recip_in=%h busy=%b data=%h want 1 0 00 0 00",
               bus.in_ready, bus.out_valid, bus.recip_in, bus.busy, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;

    send4(32'h40404040, t0);
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (!seen || bus.out_valid !== 1'b1 || bus.out_data !== 8'h3F) begin
      n_fail++;
      $display("FAIL abort_emit_pre: got seen=%b valid=%b data=%0d want 1 1 63", seen, bus.out_valid, bus.out_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.recip_in !== 8'h00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_emit: got in_ready=%b valid=%b last=%b data=%h recip_in=%h busy=%b want 1 0 0 00 00 0",
               bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.recip_in, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vector("after_abort", 32'h40404040, 32'h3F3F3F3F, 8'h80, 6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_single_one();
    test_zero_sum();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000 want finished");
    $fatal(1);
  end
endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Sequential front/back end for the reciprocal PWL approximation in the pseudo-softmax datapath.
- Collects a vector of N_ELEM exponent values and accumulates their sum, then normalizes the sum to a Q1.7 mantissa and drives it to the reciprocal unit.
- Captures the returned reciprocal and streams out x_i/sum as Q0.8 probabilities with a valid/ready handshake.

Parameters:
- N_ELEM, 4, elements per vector (≥2, power of two)
- DATA_W, 8, element / probability width
- RECIP_LAT, 1, cycles from recip_in change to valid recip_out (registered reciprocal unit = 1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_W  unsigned exponent value x_i
- recip_in  output  8  normalized sum mantissa, Q1.7, bit7=1 when sum≠0
- recip_out  input  8  reciprocal of recip_in, Q0.8 (0xFF represents 1.0)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  DATA_W  probability x_i/sum, Q0.8, saturated
- out_last  output  1  marks element N_ELEM-1
- busy  output  1  high in every state except FILL with count=0

Behaviour:
- Reset (async, rst_n=0): state=FILL, count=0, sum=0, buffer cleared; in_ready=1, out_valid=0, out_last=0, out_data=0, recip_in=0, busy=0.
- SUM_W = DATA_W + log2(N_ELEM); sum never overflows.
- FILL:
  - in_ready=1.
  - Each in_valid&&in_ready stores in_data into buf[count], adds it to sum, and increments count.
  - On accepting element N_ELEM-1, go to NORM next cycle.
- NORM (1 cycle):
  - in_ready=0.
  - p = index of the MSB set in sum.
  - recip_in registered as sum[p:p-7], zero-padded on the right when p<7; truncation is floor.
  - sum=0: recip_in=0, r forced to 0, go directly to EMIT; otherwise go to WAIT.
- WAIT:
  - recip_in held stable.
  - After exactly RECIP_LAT cycles, capture r=recip_out and go to EMIT.
- EMIT:
  - out_valid=1.
  - out_data = min((buf[k]*r) >> p, 2^DATA_W-1); product width DATA_W+8.
  - out_last=1 when k=N_ELEM-1.
  - out_data/out_last held stable while out_valid&&!out_ready.
  - k advances on handshake.
  - Handshake on k=N_ELEM-1: out_valid drops next cycle, count/sum/k clear, state=FILL, in_ready=1 that same next cycle.
- Input arriving outside FILL is not accepted (in_ready=0); the upstream holds it.
- Exactly one element is accepted or emitted per cycle. There is no overlap between vectors.
- rst_n asserted in any state aborts the vector immediately: partial sum discarded, outputs return to reset values.
- Latency, first accept to first out_valid = N_ELEM + 1 + RECIP_LAT cycles when in_valid is continuous (N_ELEM+1 when sum=0).

Test Plan:
- N_ELEM=4, inputs 64,64,64,64; bench reciprocal model returns 0xFF for 0x80 with 1-cycle latency -> sum=256, p=8, recip_in=0x80; outputs 63,63,63,63 with out_last on the 4th; first out_valid 6 cycles after the first accept.
- Inputs 1,0,0,0 -> p=0, recip_in=0x80, r=0xFF; outputs 255,0,0,0 (255 saturated/exact).
- Inputs 0,0,0,0 -> recip_in=0, no WAIT cycle; outputs 0,0,0,0; first out_valid 5 cycles after the first accept.
- Inputs 200,100,50,10 (sum=360, p=8, recip_in=0xB4); model returns 0xB6 -> outputs 142,71,35,7.
- Backpressure: out_ready low for 3 cycles on element 1 -> out_data/out_last stable, no element skipped or duplicated; in_ready stays 0 until the last handshake, then 1 the next cycle.
- Reset: rst_n pulsed low mid-WAIT and again mid-EMIT -> all outputs at reset values immediately; the next vector 64×4 produces 63×4 correctly.
